// File: rtl/exmem_stage_elastic.sv
// exmem_stage_elastic: EX/MEM stage register with valid/ready flow control, optional skid entry and flush
module exmem_stage_elastic #(
    parameter int DATA_W = 32,
    parameter int RW_W   = 5,
    parameter int M_W    = 2,
    parameter int WB_W   = 1,
    parameter int SKID   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_alures,
    input  logic [DATA_W-1:0] i_busB,
    input  logic [RW_W-1:0]   i_Rw,
    input  logic [M_W-1:0]    i_M,
    input  logic [WB_W-1:0]   i_WB,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_alures,
    output logic [DATA_W-1:0] o_busB,
    output logic [RW_W-1:0]   o_Rw,
    output logic [M_W-1:0]    o_M,
    output logic [WB_W-1:0]   o_WB,
    output logic [1:0]        o_occupancy
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t            state;
    logic [DATA_W-1:0] s_alures, s_busB;
    logic [RW_W-1:0]   s_Rw;
    logic [M_W-1:0]    s_M;
    logic [WB_W-1:0]   s_WB;
    logic              in_xfer, out_xfer;
    assign o_valid     = state != EMPTY;
    assign o_occupancy = state;
    assign o_ready     = SKID != 0 ? state != FULL : i_ready | ~o_valid;
    assign in_xfer     = i_valid & o_ready;
    assign out_xfer    = o_valid & i_ready;
    // occupancy FSM moving entries input -> output register, or input -> skid -> output register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= EMPTY;
            o_alures <= '0;
            o_busB   <= '0;
            o_Rw     <= '0;
            o_M      <= '0;
            o_WB     <= '0;
            s_alures <= '0;
            s_busB   <= '0;
            s_Rw     <= '0;
            s_M      <= '0;
            s_WB     <= '0;
        end else if (i_flush) begin
            state <= EMPTY;
            o_M   <= '0;
            o_WB  <= '0;
            s_M   <= '0;
            s_WB  <= '0;
        end else begin
            case (state)
                EMPTY: if (in_xfer) begin
                    o_alures <= i_alures;
                    o_busB   <= i_busB;
                    o_Rw     <= i_Rw;
                    o_M      <= i_M;
                    o_WB     <= i_WB;
                    state    <= ONE;
                end
                ONE: if (in_xfer && out_xfer) begin
                    o_alures <= i_alures;
                    o_busB   <= i_busB;
                    o_Rw     <= i_Rw;
                    o_M      <= i_M;
                    o_WB     <= i_WB;
                end else if (in_xfer) begin
                    s_alures <= i_alures;
                    s_busB   <= i_busB;
                    s_Rw     <= i_Rw;
                    s_M      <= i_M;
                    s_WB     <= i_WB;
                    state    <= FULL;
                end else if (out_xfer) begin
                    o_M   <= '0;
                    o_WB  <= '0;
                    state <= EMPTY;
                end
                FULL: if (out_xfer) begin
                    o_alures <= s_alures;
                    o_busB   <= s_busB;
                    o_Rw     <= s_Rw;
                    o_M      <= s_M;
                    o_WB     <= s_WB;
                    state    <= ONE;
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule
